// File: rtl/panel_reg_pkg.sv
// Shared address map and bit positions for the panel register bank.
// Imported by the bank top and its shadow-commit helper.
package panel_reg_pkg;

    localparam logic [7:0] ADDR_ID         = 8'h00;
    localparam logic [7:0] ADDR_CTRL       = 8'h01;
    localparam logic [7:0] ADDR_CMD        = 8'h02;
    localparam logic [7:0] ADDR_STATUS     = 8'h03;
    localparam logic [7:0] ADDR_INT_STAT   = 8'h04;
    localparam logic [7:0] ADDR_INT_EN     = 8'h05;
    localparam logic [7:0] ADDR_H_ACTIVE   = 8'h06;
    localparam logic [7:0] ADDR_V_ACTIVE   = 8'h07;
    localparam logic [7:0] ADDR_INTEG_TIME = 8'h08;
    localparam logic [7:0] ADDR_FRAME_CNT  = 8'h09;
    localparam logic [7:0] ADDR_ERR_CNT    = 8'h0A;
    localparam logic [7:0] ADDR_SCRATCH    = 8'h0B;

    localparam int CTRL_PANEL_EN = 0;
    localparam int CTRL_TEST_PAT = 1;
    localparam int CTRL_GATE_LSB = 4;
    localparam int CTRL_GATE_W   = 4;
    // Only bits [7:4], [1] and [0] of CTRL exist; the rest read back 0.
    localparam logic [7:0] CTRL_MASK = 8'hF3;

    localparam int INT_W          = 3;
    localparam int INT_FRAME_DONE = 0;
    localparam int INT_LINE_ERR   = 1;
    localparam int INT_FIFO_OVF   = 2;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/panel_reg_bank_shadow.sv
// Staging/committed register pair for one double-buffered timing field.
// The committed copy only moves when commit_i sees a pending staged value.
module reg_shadow_commit
    import panel_reg_pkg::*;
#(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             commit_i,
    output logic [WIDTH-1:0] staged_o,
    output logic [WIDTH-1:0] active_o,
    output logic             pending_o
);

    logic [WIDTH-1:0] staged_q, staged_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;

    // A write landing on a commit cycle keeps pending set so the new value
    // waits for the following commit point.
    always_comb begin
        staged_d  = staged_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (commit_i && pending_q) begin
            active_d  = staged_q;
            pending_d = 1'b0;
        end
        if (wr_en_i) begin
            staged_d  = wdata_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_q  <= RESET;
            active_q  <= RESET;
            pending_q <= 1'b0;
        end else begin
            staged_q  <= staged_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign staged_o  = staged_q;
    assign active_o  = active_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/panel_reg_bank.sv
// Panel register file behind the SPI slave: control, double-buffered timing,
// sticky W1C interrupts, event counters and a registered read port.
module panel_reg_bank
    import panel_reg_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = 32'h5446_5401,
    parameter logic [11:0] H_DEF     = 12'd1024,
    parameter logic [11:0] V_DEF     = 12'd1024,
    parameter logic [23:0] INTEG_DEF = 24'd10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_write,
    input  logic        reg_read,
    output logic [31:0] reg_rdata,
    input  logic        busy,
    input  logic        frame_sync,
    input  logic        evt_frame_done,
    input  logic        evt_line_err,
    input  logic        evt_fifo_ovf,
    output logic        panel_en,
    output logic        test_pattern_en,
    output logic [3:0]  gate_mode,
    output logic [11:0] h_active,
    output logic [11:0] v_active,
    output logic [23:0] integ_time,
    output logic        frame_start,
    output logic        soft_rst,
    output logic        irq
);

    logic              wr_prev_q, rd_prev_q;
    logic              wr_edge, rd_edge;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [INT_W-1:0]  int_stat_q, int_stat_d;
    logic [INT_W-1:0]  int_en_q, int_en_d;
    logic [INT_W-1:0]  evt_vec;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              frame_start_q, frame_start_d;
    logic              soft_rst_q, soft_rst_d;
    logic              irq_q, irq_d;

    logic              commit;
    logic              h_pend, v_pend, t_pend, shadow_pending;
    logic [11:0]       h_staged, v_staged;
    logic [23:0]       t_staged;

    // Level requests act only on their rising edge.
    assign wr_edge = reg_write && !wr_prev_q;
    assign rd_edge = reg_read && !rd_prev_q;
    assign evt_vec = {evt_fifo_ovf, evt_line_err, evt_frame_done};

    // Idle panel commits immediately; a running panel waits for frame_sync.
    assign commit         = ctrl_q[CTRL_PANEL_EN] ? frame_sync : 1'b1;
    assign shadow_pending = h_pend || v_pend || t_pend;

    reg_shadow_commit #(.WIDTH(12), .RESET(H_DEF)) u_h_active (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_edge && (reg_addr == ADDR_H_ACTIVE)),
        .wdata_i(reg_wdata[11:0]), .commit_i(commit),
        .staged_o(h_staged), .active_o(h_active), .pending_o(h_pend)
    );

    reg_shadow_commit #(.WIDTH(12), .RESET(V_DEF)) u_v_active (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_edge && (reg_addr == ADDR_V_ACTIVE)),
        .wdata_i(reg_wdata[11:0]), .commit_i(commit),
        .staged_o(v_staged), .active_o(v_active), .pending_o(v_pend)
    );

    reg_shadow_commit #(.WIDTH(24), .RESET(INTEG_DEF)) u_integ_time (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_edge && (reg_addr == ADDR_INTEG_TIME)),
        .wdata_i(reg_wdata[23:0]), .commit_i(commit),
        .staged_o(t_staged), .active_o(integ_time), .pending_o(t_pend)
    );

    always_comb begin
        ctrl_d        = ctrl_q;
        int_en_d      = int_en_q;
        scratch_d     = scratch_q;
        int_stat_d    = int_stat_q;
        frame_start_d = 1'b0;
        soft_rst_d    = 1'b0;
        if (wr_edge) begin
            case (reg_addr)
                ADDR_CTRL:     ctrl_d     = reg_wdata[7:0] & CTRL_MASK;
                ADDR_INT_EN:   int_en_d   = reg_wdata[INT_W-1:0];
                ADDR_SCRATCH:  scratch_d  = reg_wdata;
                ADDR_INT_STAT: int_stat_d = int_stat_q & ~reg_wdata[INT_W-1:0];
                ADDR_CMD: begin
                    frame_start_d = reg_wdata[0];
                    soft_rst_d    = reg_wdata[1];
                end
                default: ;
            endcase
        end
        // Hardware set is applied after the W1C clear so set wins.
        int_stat_d  = int_stat_d | evt_vec;
        frame_cnt_d = frame_cnt_q + {31'd0, evt_frame_done};
        irq_d       = |(int_stat_q & int_en_q);
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rd_edge && (reg_addr == ADDR_ERR_CNT)) begin
            err_cnt_d = evt_line_err ? 16'd1 : 16'd0;
        end else if (evt_line_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (reg_addr)
            ADDR_ID:         rdata_d = ID_VALUE;
            ADDR_CTRL:       rdata_d = {24'd0, ctrl_q};
            ADDR_STATUS:     rdata_d = {30'd0, shadow_pending, busy};
            ADDR_INT_STAT:   rdata_d = {{(32-INT_W){1'b0}}, int_stat_q};
            ADDR_INT_EN:     rdata_d = {{(32-INT_W){1'b0}}, int_en_q};
            ADDR_H_ACTIVE:   rdata_d = {20'd0, h_staged};
            ADDR_V_ACTIVE:   rdata_d = {20'd0, v_staged};
            ADDR_INTEG_TIME: rdata_d = {8'd0, t_staged};
            ADDR_FRAME_CNT:  rdata_d = frame_cnt_q;
            ADDR_ERR_CNT:    rdata_d = {16'd0, err_cnt_q};
            ADDR_SCRATCH:    rdata_d = scratch_q;
            default:         rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prev_q     <= 1'b0;
            rd_prev_q     <= 1'b0;
            ctrl_q        <= '0;
            int_stat_q    <= '0;
            int_en_q      <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
            scratch_q     <= '0;
            rdata_q       <= '0;
            frame_start_q <= 1'b0;
            soft_rst_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            wr_prev_q     <= reg_write;
            rd_prev_q     <= reg_read;
            ctrl_q        <= ctrl_d;
            int_stat_q    <= int_stat_d;
            int_en_q      <= int_en_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
            scratch_q     <= scratch_d;
            rdata_q       <= rdata_d;
            frame_start_q <= frame_start_d;
            soft_rst_q    <= soft_rst_d;
            irq_q         <= irq_d;
        end
    end

    assign reg_rdata       = rdata_q;
    assign panel_en        = ctrl_q[CTRL_PANEL_EN];
    assign test_pattern_en = ctrl_q[CTRL_TEST_PAT];
    assign gate_mode       = ctrl_q[CTRL_GATE_LSB +: CTRL_GATE_W];
    assign frame_start     = frame_start_q;
    assign soft_rst        = soft_rst_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_panel_reg_bank.sv
// Bench for panel_reg_bank: directed register-map sequences plus a random
// phase, all cross-checked every cycle against a register-map reference model.
module tb_panel_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write, reg_read;
    logic [31:0] reg_rdata;
    logic        busy, frame_sync, evt_frame_done, evt_line_err, evt_fifo_ovf;
    logic        panel_en, test_pattern_en;
    logic [3:0]  gate_mode;
    logic [11:0] h_active, v_active;
    logic [23:0] integ_time;
    logic        frame_start, soft_rst, irq;

    int checks = 0;
    int errors = 0;
    int fs_pulses = 0;
    int sr_pulses = 0;
    bit chk_en = 1'b0;

    panel_reg_bank dut (
        .clk(clk), .rst_n(rst_n),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_write(reg_write), .reg_read(reg_read), .reg_rdata(reg_rdata),
        .busy(busy), .frame_sync(frame_sync),
        .evt_frame_done(evt_frame_done), .evt_line_err(evt_line_err), .evt_fifo_ovf(evt_fifo_ovf),
        .panel_en(panel_en), .test_pattern_en(test_pattern_en), .gate_mode(gate_mode),
        .h_active(h_active), .v_active(v_active), .integ_time(integ_time),
        .frame_start(frame_start), .soft_rst(soft_rst), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_wr_prev, m_rd_prev, m_pend, m_fs, m_sr, m_irq;
    logic [7:0]  m_ctrl;
    logic [2:0]  m_stat, m_en;
    logic [31:0] m_stage[3];
    logic [31:0] m_act[3];
    logic [31:0] m_fcnt, m_scr, m_rdata;
    logic [15:0] m_ecnt;
    logic [31:0] m_mask[3] = '{32'h0000_0FFF, 32'h0000_0FFF, 32'h00FF_FFFF};
    logic [31:0] m_def[3]  = '{32'd1024, 32'd1024, 32'd10000};

    function automatic logic [31:0] m_read(input logic [7:0] a);
        if (a == 8'h00) return 32'h5446_5401;
        if (a == 8'h01) return {24'd0, m_ctrl};
        if (a == 8'h03) return {30'd0, m_pend, busy};
        if (a == 8'h04) return {29'd0, m_stat};
        if (a == 8'h05) return {29'd0, m_en};
        if (a >= 8'h06 && a <= 8'h08) return m_stage[a - 8'h06];
        if (a == 8'h09) return m_fcnt;
        if (a == 8'h0A) return {16'd0, m_ecnt};
        if (a == 8'h0B) return m_scr;
        return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr_prev = 0; m_rd_prev = 0; m_pend = 0; m_fs = 0; m_sr = 0; m_irq = 0;
            m_ctrl = 0; m_stat = 0; m_en = 0; m_fcnt = 0; m_scr = 0; m_rdata = 0; m_ecnt = 0;
            for (int i = 0; i < 3; i++) begin
                m_stage[i] = m_def[i];
                m_act[i]   = m_def[i];
            end
        end else begin
            bit we, re, cm;
            logic [2:0] old_stat;
            we = reg_write && !m_wr_prev;
            re = reg_read && !m_rd_prev;
            old_stat = m_stat;
            m_rdata = m_read(reg_addr);
            m_irq = |(old_stat & m_en);
            cm = m_pend && (m_ctrl[0] ? frame_sync : 1'b1);
            if (cm) begin
                for (int i = 0; i < 3; i++) m_act[i] = m_stage[i];
                m_pend = 0;
            end
            if (re && reg_addr == 8'h0A) m_ecnt = evt_line_err ? 16'd1 : 16'd0;
            else if (evt_line_err && m_ecnt < 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
            m_fcnt = m_fcnt + (evt_frame_done ? 32'd1 : 32'd0);
            m_fs = we && reg_addr == 8'h02 && reg_wdata[0];
            m_sr = we && reg_addr == 8'h02 && reg_wdata[1];
            if (we) begin
                if (reg_addr == 8'h01) m_ctrl = reg_wdata[7:0] & 8'hF3;
                if (reg_addr == 8'h04) m_stat = m_stat & ~reg_wdata[2:0];
                if (reg_addr == 8'h05) m_en = reg_wdata[2:0];
                if (reg_addr == 8'h0B) m_scr = reg_wdata;
                if (reg_addr >= 8'h06 && reg_addr <= 8'h08) begin
                    m_stage[reg_addr - 8'h06] = reg_wdata & m_mask[reg_addr - 8'h06];
                    m_pend = 1;
                end
            end
            m_stat = m_stat | {evt_fifo_ovf, evt_line_err, evt_frame_done};
            m_wr_prev = reg_write;
            m_rd_prev = reg_read;
        end
    end

    logic [88:0] dut_vec, mdl_vec;
    assign dut_vec = {reg_rdata, panel_en, test_pattern_en, gate_mode, h_active, v_active,
                      integ_time, frame_start, soft_rst, irq};
    assign mdl_vec = {m_rdata, m_ctrl[0], m_ctrl[1], m_ctrl[7:4], m_act[0][11:0], m_act[1][11:0],
                      m_act[2][23:0], m_fs, m_sr, m_irq};

    always @(negedge clk) begin
        if (chk_en) chk("model", {7'd0, dut_vec}, {7'd0, mdl_vec});
        if (frame_start) fs_pulses++;
        if (soft_rst) sr_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input int hold);
        step();
        reg_addr = a; reg_wdata = d; reg_write = 1'b1;
        repeat (hold) step();
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        step();
        reg_addr = a; reg_read = 1'b1;
        step();
        d = reg_rdata;
        reg_read = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t rv[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [56:0] snap;

        rv[0]  = '{8'h00, 32'h5446_5401}; rv[1]  = '{8'h01, 32'd0};
        rv[2]  = '{8'h02, 32'd0};         rv[3]  = '{8'h03, 32'd0};
        rv[4]  = '{8'h04, 32'd0};         rv[5]  = '{8'h05, 32'd0};
        rv[6]  = '{8'h06, 32'h400};       rv[7]  = '{8'h07, 32'h400};
        rv[8]  = '{8'h08, 32'h2710};      rv[9]  = '{8'h09, 32'd0};
        rv[10] = '{8'h0A, 32'd0};         rv[11] = '{8'h0B, 32'd0};
        rv[12] = '{8'h0C, 32'd0};         rv[13] = '{8'hFF, 32'd0};

        // clock/reset
        rst_n = 1'b0; reg_addr = 0; reg_wdata = 0; reg_write = 0; reg_read = 0;
        busy = 0; frame_sync = 0; evt_frame_done = 0; evt_line_err = 0; evt_fifo_ovf = 0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_irq", {95'd0, irq}, 96'd0);
        chk("rst_panel_en", {95'd0, panel_en}, 96'd0);
        chk("rst_rdata", {64'd0, reg_rdata}, 96'd0);

        for (int i = 0; i < 14; i++) begin
            step();
            reg_addr = rv[i].addr;
            step();
            chk($sformatf("reset_read_%0h", rv[i].addr), {64'd0, reg_rdata}, {64'd0, rv[i].exp});
        end

        // level strobes: held write acts once
        wr(8'h01, 32'h31, 20);
        chk("ctrl_panel_en", {95'd0, panel_en}, 96'd1);
        chk("ctrl_gate_mode", {92'd0, gate_mode}, 96'd3);
        chk("ctrl_test_pat", {95'd0, test_pattern_en}, 96'd0);
        fs_pulses = 0; sr_pulses = 0;
        wr(8'h02, 32'h1, 5);
        repeat (3) step();
        chk("frame_start_pulses", 96'(fs_pulses), 96'd1);
        chk("soft_rst_pulses", 96'(sr_pulses), 96'd0);
        rd(8'h02, d);
        chk("cmd_reads_zero", {64'd0, d}, 96'd0);

        // shadow commit with panel running
        wr(8'h06, 32'h500, 1);
        step();
        chk("shadow_hold", {84'd0, h_active}, 96'h400);
        rd(8'h03, d);
        chk("status_pending", {95'd0, d[1]}, 96'd1);
        rd(8'h06, d);
        chk("staging_read", {64'd0, d}, 96'h500);
        step(); frame_sync = 1'b1;
        step(); frame_sync = 1'b0;
        chk("shadow_commit", {84'd0, h_active}, 96'h500);
        rd(8'h03, d);
        chk("status_cleared", {95'd0, d[1]}, 96'd0);

        // interrupts
        wr(8'h05, 32'h1, 1);
        step(); evt_frame_done = 1'b1;
        step(); evt_frame_done = 1'b0;
        step();
        chk("irq_set", {95'd0, irq}, 96'd1);
        rd(8'h09, d);
        chk("frame_cnt_1", {64'd0, d}, 96'd1);
        step();
        reg_addr = 8'h04; reg_wdata = 32'h1; reg_write = 1'b1; evt_frame_done = 1'b1;
        step();
        reg_write = 1'b0; evt_frame_done = 1'b0;
        step();
        chk("set_wins_irq", {95'd0, irq}, 96'd1);
        rd(8'h04, d);
        chk("set_wins_stat", {64'd0, d}, 96'd1);
        rd(8'h09, d);
        chk("frame_cnt_2", {64'd0, d}, 96'd2);
        wr(8'h04, 32'h1, 1);
        step();
        chk("w1c_irq_clear", {95'd0, irq}, 96'd0);

        // error counter: count, read-clear, saturate, clear vs event
        step(); evt_line_err = 1'b1;
        repeat (3) step();
        evt_line_err = 1'b0;
        rd(8'h0A, d);
        chk("err_cnt_3", {64'd0, d}, 96'd3);
        rd(8'h0A, d);
        chk("err_cnt_cleared", {64'd0, d}, 96'd0);
        step(); reg_addr = 8'h00; evt_line_err = 1'b1;
        repeat (65536) step();
        evt_line_err = 1'b0; reg_addr = 8'h0A;
        step();
        chk("err_cnt_sat", {64'd0, reg_rdata}, 96'hFFFF);
        reg_read = 1'b1; evt_line_err = 1'b1;
        step();
        reg_read = 1'b0; evt_line_err = 1'b0;
        chk("err_clear_read", {64'd0, reg_rdata}, 96'hFFFF);
        step();
        chk("err_clear_vs_evt", {64'd0, reg_rdata}, 96'd1);

        // unmapped access
        step();
        snap = dut_vec[56:0];
        wr(8'hFF, 32'hDEAD_BEEF, 1);
        rd(8'hFF, d);
        chk("unmapped_read", {64'd0, d}, 96'd0);
        chk("unmapped_no_effect", {39'd0, dut_vec[56:0]}, {39'd0, snap});

        // randomized traffic, model comparison every cycle
        for (int i = 0; i < 3000; i++) begin
            step();
            reg_addr       = 8'($urandom_range(0, 15));
            reg_wdata      = $urandom;
            reg_write      = ($urandom_range(0, 2) == 0);
            reg_read       = ($urandom_range(0, 2) == 0);
            busy           = 1'($urandom_range(0, 1));
            frame_sync     = ($urandom_range(0, 7) == 0);
            evt_frame_done = ($urandom_range(0, 5) == 0);
            evt_line_err   = ($urandom_range(0, 5) == 0);
            evt_fifo_ovf   = ($urandom_range(0, 5) == 0);
        end
        step();
        reg_write = 0; reg_read = 0; frame_sync = 0;
        evt_frame_done = 0; evt_line_err = 0; evt_fifo_ovf = 0; busy = 0;
        repeat (3) step();

        // reset in the middle of a held write
        wr(8'h06, 32'h123, 1);
        reg_addr = 8'h01; reg_wdata = 32'hF3; reg_write = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdata", {64'd0, reg_rdata}, 96'd0);
        chk("midrst_ctrl", {90'd0, panel_en, test_pattern_en, gate_mode}, 96'd0);
        chk("midrst_timing", {48'd0, h_active, v_active, integ_time}, {48'd0, 12'd1024, 12'd1024, 24'd10000});
        chk("midrst_pulses", {93'd0, frame_start, soft_rst, irq}, 96'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_write", {90'd0, panel_en, test_pattern_en, gate_mode}, {90'd0, 1'b1, 1'b1, 4'hF});
        reg_write = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/panel_reg_bank.md
Name: panel_reg_bank

Overview:
- Register file directly downstream of spi_slave_interface.
- Consumes reg_addr/reg_wdata/reg_write/reg_read and returns reg_rdata.
- Drives panel control, timing and IRQ outputs to the panel timing/readout logic.
- Timing registers are double-buffered and commit at frame boundaries; interrupt flags are sticky W1C.

Parameters:
ID_VALUE, 32'h5446_5401, value returned at ID register
H_DEF, 12'd1024, reset value of H_ACTIVE
V_DEF, 12'd1024, reset value of V_ACTIVE
INTEG_DEF, 24'd10000, reset value of INTEG_TIME

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
reg_addr  in  8  register word address from SPI slave
reg_wdata  in  32  write data from SPI slave
reg_write  in  1  write request, level; acted on at rising edge only
reg_read  in  1  read request, level; acted on at rising edge only
reg_rdata  out  32  registered read data
busy  in  1  panel engine busy (status)
frame_sync  in  1  1-cycle pulse at frame boundary (shadow commit point)
evt_frame_done  in  1  1-cycle event pulse
evt_line_err  in  1  1-cycle event pulse
evt_fifo_ovf  in  1  1-cycle event pulse
panel_en  out  1  CTRL[0]
test_pattern_en  out  1  CTRL[1]
gate_mode  out  4  CTRL[7:4]
h_active  out  12  committed H_ACTIVE
v_active  out  12  committed V_ACTIVE
integ_time  out  24  committed INTEG_TIME
frame_start  out  1  1-cycle pulse from CMD[0]
soft_rst  out  1  1-cycle pulse from CMD[1]
irq  out  1  registered OR of (INT_STAT & INT_EN)

Behaviour:
- Strobes: internal wr_prev/rd_prev flops.
  - A write commits at the first clk edge where reg_write=1 and wr_prev=0.
  - A held-high reg_write performs exactly one write. Read edge is detected the same way.
- Register map (word address, access, width, reset):
  - 0x00 ID: RO, 32, = ID_VALUE.
  - 0x01 CTRL: RW, bits [0],[1],[7:4], reset 0; unused bits read 0.
  - 0x02 CMD: WO, self-clearing.
    - Bit0 → frame_start high exactly the cycle after the write edge.
    - Bit1 → soft_rst likewise.
    - Reads 0.
  - 0x03 STATUS: RO; [0]=busy, [1]=shadow_pending.
  - 0x04 INT_STAT: W1C, [2:0] = {fifo_ovf, line_err, frame_done}, reset 0.
    - Hardware event sets its bit.
    - Set and W1C clear of the same bit in the same cycle → bit stays 1 (set wins).
  - 0x05 INT_EN: RW [2:0], reset 0.
  - 0x06 H_ACTIVE, 0x07 V_ACTIVE, 0x08 INTEG_TIME: RW staging registers.
    - Reset to H_DEF/V_DEF/INTEG_DEF.
    - Reads return staging value.
  - 0x09 FRAME_CNT: RO 32; +1 per evt_frame_done; wraps 0xFFFF_FFFF→0.
  - 0x0A ERR_CNT: RO 16; +1 per evt_line_err; saturates at 0xFFFF.
    - Cleared by the read edge at this address.
    - Clear and increment in the same cycle → 1.
  - 0x0B SCRATCH: RW 32, reset 0.
  - All other addresses: read 0, writes ignored, no side effects.
- Shadow commit:
  - Any write to 0x06–0x08 sets shadow_pending.
  - When panel_en=0, staging copies to committed outputs on the next clk (pending clears).
  - When panel_en=1, copy occurs only on the cycle frame_sync=1; pending clears the same cycle.
  - A write coinciding with frame_sync: the new value is written to staging, pending remains 1, and the commit happens at the next frame_sync.
- reg_rdata: registered, = map[reg_addr] with 1-cycle latency, updated every cycle regardless of reg_read.
- irq: registered, 1-cycle after INT_STAT/INT_EN change.
- Reset (async, any time incl. mid-access): all registers and counters to reset values.
  - Outputs after reset:
    - reg_rdata=0, frame_start=0, soft_rst=0, irq=0
    - panel_en=0, test_pattern_en=0, gate_mode=0
    - h_active=H_DEF, v_active=V_DEF, integ_time=INTEG_DEF
  - wr_prev/rd_prev reset to 0, so a reg_write still high after reset release is treated as a new write.

Decomposition:
- Package panel_reg_pkg: address localparams (ADDR_ID..ADDR_SCRATCH), CTRL/INT bit-position constants, INT_W=3.
- One sub-module reg_shadow_commit: staging + committed registers for one field.
  - Parameter WIDTH, RESET value.
  - Inputs wr_en, wdata, commit; outputs staged, active, pending.
  - Instantiated for H_ACTIVE, V_ACTIVE, INTEG_TIME.

Test Plan:
- Reset values: after reset, read 0x00→0x54465401, 0x06→0x400, 0x08→0x2710; irq=0, panel_en=0.
- Level strobe: write CTRL=0x31 with reg_write held 20 cycles, then write CMD=0x1 held 5 cycles → panel_en=1, gate_mode=3, frame_start exactly one pulse.
- Shadow:
  - With panel_en=1, write H_ACTIVE=0x500 → h_active stays 0x400 and STATUS[1]=1.
  - Pulse frame_sync → h_active=0x500 next cycle, STATUS[1]=0.
- Interrupts:
  - INT_EN=0x1, pulse evt_frame_done → irq=1, FRAME_CNT=1.
  - Write INT_STAT=0x1 on the same cycle as a second evt_frame_done → bit stays 1, FRAME_CNT=2.
  - Clean W1C → irq=0.
- ERR_CNT:
  - 3 evt_line_err → read 0x0A returns 3, then reads 0.
  - Forced 0xFFFF plus an event stays 0xFFFF.
  - Read-clear coincident with an event → 1.
- Unmapped/mid-op reset:
  - Write 0xFF then read → 0, no output change.
  - Assert rst_n low while reg_write=1 → all outputs at reset values within the same cycle.
